// File: rtl/mmcm_test_pkg.sv
// mmcm_test_pkg: shared definitions for the MMCM frequency checker.
//   state_t   - FSM state encoding (IDLE=0, WAIT_LOCK=1, MEASURE=2, EVAL=3),
//               exposed on O_STATE
//   LOSS_W    - width of the saturating lock-loss event counter (O_LOSS)
//   ctr_width - bits needed for a counter that must hold values 0..max_val
package mmcm_test_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    MEASURE   = 2'd2,
    EVAL      = 2'd3
  } state_t;

  localparam int LOSS_W = 8;

  function automatic int ctr_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mmcm_edge_counter.sv
// mmcm_edge_counter: one measured channel.
//   Synchronizes an asynchronous divide-by-2 toggle (2 FFs), detects any
//   change with a third flop, and counts changes into a saturating counter.
//   Ports:
//     clk, rstn        - system clock, synchronous active-low reset
//     tog              - asynchronous toggle from the MMCM output domain
//     clr              - clear the counter (start of a gate window)
//     cnt_en           - count detected changes this cycle
//     exp_min, exp_max - inclusive pass bounds for the count
//     cnt_next         - count value as it will be after this cycle
//     in_range         - cnt_next lies within [exp_min, exp_max]
module mmcm_edge_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tog,
  input  logic                 clr,
  input  logic                 cnt_en,
  input  logic [CNT_WIDTH-1:0] exp_min,
  input  logic [CNT_WIDTH-1:0] exp_max,
  output logic [CNT_WIDTH-1:0] cnt_next,
  output logic                 in_range
);

  // tog_q[1:0] is the synchronizer, tog_q[2] the edge-detect history
  logic [2:0]           tog_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 toggled;
  logic                 inc;

  always_ff @(posedge clk) begin
    if (!rstn) tog_q <= '0;
    else       tog_q <= {tog_q[1:0], tog};
  end

  assign toggled = tog_q[1] ^ tog_q[2];
  assign inc     = cnt_en & toggled & ~(&cnt);

  // cnt_next is exported so the final gate cycle's edge can be included
  // when the result is latched on the same clock edge.
  assign cnt_next = cnt + CNT_WIDTH'(inc);
  assign in_range = (cnt_next >= exp_min) && (cnt_next <= exp_max);

  always_ff @(posedge clk) begin
    if (!rstn)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else           cnt <= cnt_next;
  end

endmodule

// File: rtl/mmcm_freq_check.sv
// mmcm_freq_check: measures CHANNELS MMCM output clocks against CLK.
//   After LOCK_HOLD consecutive locked cycles, counts toggle edges of each
//   channel over GATE_CYCLES CLK cycles, then reports counts and per-channel
//   range pass/fail. Measurement repeats continuously while I_EN=1.
//   Ports:
//     CLK, RSTN   - system clock, synchronous active-low reset
//     I_EN        - run enable (0 returns to IDLE, results held)
//     I_LOCKED    - MMCM lock, asynchronous
//     I_TOG       - per-channel divide-by-2 toggles, asynchronous
//     O_STATE     - FSM state (IDLE/WAIT_LOCK/MEASURE/EVAL)
//     O_DONE      - one-cycle strobe when a new result is latched
//     O_VALID     - sticky: at least one result present
//     O_PASS      - per-channel count within [EXP_MIN, EXP_MAX]
//     O_FAIL_ANY  - some channel failed in the latched result
//     O_CNT       - latched counts, channel k at [k*CNT_WIDTH +: CNT_WIDTH]
//     O_LOSS      - lock-loss events during measurement, saturating
module mmcm_freq_check
  import mmcm_test_pkg::*;
#(
  parameter int                            CHANNELS    = 4,
  parameter int                            CNT_WIDTH   = 16,
  parameter int                            GATE_CYCLES = 10000,
  parameter int                            LOCK_HOLD   = 256,
  parameter logic [CHANNELS*CNT_WIDTH-1:0] EXP_MIN     = '0,
  parameter logic [CHANNELS*CNT_WIDTH-1:0] EXP_MAX     = '1
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          I_EN,
  input  logic                          I_LOCKED,
  input  logic [CHANNELS-1:0]           I_TOG,
  output logic [1:0]                    O_STATE,
  output logic                          O_DONE,
  output logic                          O_VALID,
  output logic [CHANNELS-1:0]           O_PASS,
  output logic                          O_FAIL_ANY,
  output logic [CHANNELS*CNT_WIDTH-1:0] O_CNT,
  output logic [LOSS_W-1:0]             O_LOSS
);

  if (CHANNELS < 1 || CHANNELS > 7) begin : g_bad_channels
    $error("mmcm_freq_check: CHANNELS must be 1..7");
  end
  if (GATE_CYCLES < 2) begin : g_bad_gate
    $error("mmcm_freq_check: GATE_CYCLES must be at least 2");
  end
  if (LOCK_HOLD < 1) begin : g_bad_hold
    $error("mmcm_freq_check: LOCK_HOLD must be at least 1");
  end

  localparam int HOLD_W = ctr_width(LOCK_HOLD);
  localparam int GATE_W = ctr_width(GATE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_t                          state;
  logic [1:0]                      lock_q;
  logic                            lock_s;
  logic [HOLD_W-1:0]               hold;
  logic [GATE_W-1:0]               gate;
  logic                            clr;
  logic                            cnt_en;
  logic [CHANNELS*CNT_WIDTH-1:0]   cnt_next;
  logic [CHANNELS-1:0]             in_range;
  logic [LOSS_W-1:0]               loss_inc;

  always_ff @(posedge CLK) begin
    if (!RSTN) lock_q <= '0;
    else       lock_q <= {lock_q[0], I_LOCKED};
  end

  assign lock_s = lock_q[1];

  // Channel counters clear on exactly the edges where the FSM enters
  // MEASURE; these mirror the MEASURE-entry branches of the FSM below.
  assign clr    = I_EN && lock_s &&
                  ((state == WAIT_LOCK && hold == HOLD_LAST) || state == EVAL);
  assign cnt_en = (state == MEASURE);

  assign loss_inc = (O_LOSS == '1) ? O_LOSS : O_LOSS + 1'b1;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    mmcm_edge_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk      (CLK),
      .rstn     (RSTN),
      .tog      (I_TOG[k]),
      .clr      (clr),
      .cnt_en   (cnt_en),
      .exp_min  (EXP_MIN[k*CNT_WIDTH +: CNT_WIDTH]),
      .exp_max  (EXP_MAX[k*CNT_WIDTH +: CNT_WIDTH]),
      .cnt_next (cnt_next[k*CNT_WIDTH +: CNT_WIDTH]),
      .in_range (in_range[k])
    );
  end

  // Results are latched on the edge leaving the last MEASURE cycle so that
  // O_DONE and the new counts are visible during the EVAL cycle itself.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state      <= IDLE;
      hold       <= '0;
      gate       <= '0;
      O_DONE     <= 1'b0;
      O_VALID    <= 1'b0;
      O_PASS     <= '0;
      O_FAIL_ANY <= 1'b0;
      O_CNT      <= '0;
      O_LOSS     <= '0;
    end else begin
      O_DONE <= 1'b0;
      if (!I_EN) begin
        state <= IDLE;
        hold  <= '0;
        gate  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= WAIT_LOCK;
            hold  <= '0;
          end
          WAIT_LOCK: begin
            if (!lock_s) begin
              hold <= '0;
            end else if (hold == HOLD_LAST) begin
              state <= MEASURE;
              hold  <= '0;
              gate  <= '0;
            end else begin
              hold <= hold + 1'b1;
            end
          end
          MEASURE: begin
            if (!lock_s) begin
              state  <= WAIT_LOCK;
              hold   <= '0;
              O_LOSS <= loss_inc;
            end else if (gate == GATE_LAST) begin
              state      <= EVAL;
              O_CNT      <= cnt_next;
              O_PASS     <= in_range;
              O_FAIL_ANY <= ~(&in_range);
              O_DONE     <= 1'b1;
              O_VALID    <= 1'b1;
            end else begin
              gate <= gate + 1'b1;
            end
          end
          EVAL: begin
            if (lock_s) begin
              state <= MEASURE;
              gate  <= '0;
            end else begin
              state  <= WAIT_LOCK;
              hold   <= '0;
              O_LOSS <= loss_inc;
            end
          end
        endcase
      end
    end
  end

  assign O_STATE = state;

endmodule

// File: tb/tb_mmcm_freq_check.sv
// tb_mmcm_freq_check: self-checking bench for mmcm_freq_check.
//   Main DUT: 2 channels, 100-cycle gate, 8-cycle lock hold, bounds 24..26.
//   Second DUT: 1 channel, 4-bit counter, for saturation.
module tb_mmcm_freq_check;

  localparam int CH   = 2;
  localparam int W    = 16;
  localparam int GATE = 100;
  localparam int HOLD = 8;
  localparam int BMIN = 24;
  localparam int BMAX = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, en, locked;
  logic [CH-1:0] tog;
  logic          tog2;

  logic [1:0]      st, d2_st;
  logic            done, valid, fail_any, d2_done, d2_valid, d2_fail;
  logic [CH-1:0]   pass;
  logic [0:0]      d2_pass;
  logic [CH*W-1:0] cnt;
  logic [3:0]      d2_cnt;
  logic [7:0]      loss, d2_loss;

  mmcm_freq_check #(
    .CHANNELS   (CH),
    .CNT_WIDTH  (W),
    .GATE_CYCLES(GATE),
    .LOCK_HOLD  (HOLD),
    .EXP_MIN    ({16'd24, 16'd24}),
    .EXP_MAX    ({16'd26, 16'd26})
  ) dut (
    .CLK(clk), .RSTN(rstn), .I_EN(en), .I_LOCKED(locked), .I_TOG(tog),
    .O_STATE(st), .O_DONE(done), .O_VALID(valid), .O_PASS(pass),
    .O_FAIL_ANY(fail_any), .O_CNT(cnt), .O_LOSS(loss)
  );

  mmcm_freq_check #(
    .CHANNELS   (1),
    .CNT_WIDTH  (4),
    .GATE_CYCLES(GATE),
    .LOCK_HOLD  (HOLD)
  ) dut2 (
    .CLK(clk), .RSTN(rstn), .I_EN(en), .I_LOCKED(locked), .I_TOG(tog2),
    .O_STATE(d2_st), .O_DONE(d2_done), .O_VALID(d2_valid), .O_PASS(d2_pass),
    .O_FAIL_ANY(d2_fail), .O_CNT(d2_cnt), .O_LOSS(d2_loss)
  );

  int total = 0;
  int bad   = 0;
  int per[CH] = '{4, 4};
  int ph[CH]  = '{0, 0};

  // Toggle generator: channel k flips every per[k] CLK cycles.
  initial begin
    int c2;
    c2   = 0;
    tog  = '0;
    tog2 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < CH; k++) begin
        ph[k]++;
        if (ph[k] >= per[k]) begin
          ph[k]  = 0;
          tog[k] = ~tog[k];
        end
      end
      c2++;
      if (c2 >= 2) begin
        c2   = 0;
        tog2 = ~tog2;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want test to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo,
                           input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < limit);
    total++;
    if (!done) begin
      bad++;
      $display("FAIL wait_done: no O_DONE after %0d cycles, want within %0d", n, limit);
    end
  endtask

  // Reference: a toggle every p cycles produces GATE/p edges per gate window,
  // give or take one depending on phase.
  function automatic void model(input int p, output int lo, output int hi,
                                output logic ok);
    lo = GATE / p;
    hi = (GATE + p - 1) / p;
    ok = (lo >= BMIN) && (hi <= BMAX);
  endfunction

  typedef struct {
    int         p0, p1;
    int         lo0, hi0, lo1, hi1;
    logic [1:0] pass;
    logic       fail;
  } vec_t;

  task automatic check_result(input string tag, input int lo0, input int hi0,
                              input int lo1, input int hi1,
                              input logic [1:0] ep, input logic ef);
    check({tag, " state"}, st, 3);
    check({tag, " valid"}, valid, 1);
    check_rng({tag, " cnt0"}, cnt[W-1:0], lo0, hi0);
    check_rng({tag, " cnt1"}, cnt[2*W-1:W], lo1, hi1);
    check({tag, " pass"}, pass, ep);
    check({tag, " fail_any"}, fail_any, ef);
  endtask

  initial begin
    vec_t vecs[5];
    int   n, first;
    int   lo[CH], hi[CH];
    logic ok[CH];
    logic [1:0] ep;

    vecs[0] = '{4, 4, 25, 25, 25, 25, 2'b11, 1'b0};
    vecs[1] = '{4, 3, 25, 25, 33, 34, 2'b01, 1'b1};
    vecs[2] = '{3, 4, 33, 34, 25, 25, 2'b10, 1'b1};
    vecs[3] = '{5, 2, 20, 20, 50, 50, 2'b00, 1'b1};
    vecs[4] = '{7, 4, 14, 15, 25, 25, 2'b10, 1'b1};

    rstn   = 1'b0;
    en     = 1'b0;
    locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst state", st, 0);
    check("rst done", done, 0);
    check("rst valid", valid, 0);
    check("rst pass", pass, 0);
    check("rst fail_any", fail_any, 0);
    check("rst cnt", cnt, 0);
    check("rst loss", loss, 0);

    rstn   = 1'b1;
    en     = 1'b1;
    locked = 1'b1;

    // Directed periods; the first window after a period change is discarded.
    for (int i = 0; i < 5; i++) begin
      per[0] = vecs[i].p0;
      per[1] = vecs[i].p1;
      ph[0]  = 0;
      ph[1]  = 0;
      wait_done(300, n);
      wait_done(150, n);
      check("vec period", n, GATE + 1);
      check_result("vec", vecs[i].lo0, vecs[i].hi0, vecs[i].lo1, vecs[i].hi1,
                   vecs[i].pass, vecs[i].fail);
      if (i == 0) begin
        check("sat d2_done", d2_done, 1);
        check("sat d2_cnt", d2_cnt, 15);
      end
    end

    // Randomized periods and phases against the model.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < CH; k++) begin
        per[k] = int'($urandom_range(12, 2));
        ph[k]  = int'($urandom_range(per[k] - 1, 0));
        model(per[k], lo[k], hi[k], ok[k]);
      end
      ep = {ok[1], ok[0]};
      wait_done(300, n);
      wait_done(150, n);
      check_result("rand", lo[0], hi[0], lo[1], hi[1], ep, ~(&ep));
    end

    // Lock dropped for one cycle about halfway through a window.
    per[0] = 4;
    per[1] = 4;
    wait_done(300, n);
    wait_done(150, n);
    repeat (50) @(posedge clk);
    #1;
    locked = 1'b0;
    first  = 0;
    for (int c = 1; c <= 200 && first == 0; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) locked = 1'b1;
      if (c == 3) check("loss state", st, 1);
      if (done) first = c;
    end
    check("loss done delay", first, 1 + HOLD + GATE + 2);
    check("loss count", loss, 1);
    check_result("loss", 25, 25, 25, 25, 2'b11, 1'b0);

    // One-cycle reset in the middle of a window.
    repeat (30) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("mid rst state", st, 0);
    check("mid rst done", done, 0);
    check("mid rst valid", valid, 0);
    check("mid rst pass", pass, 0);
    check("mid rst fail_any", fail_any, 0);
    check("mid rst cnt", cnt, 0);
    check("mid rst loss", loss, 0);
    rstn  = 1'b1;
    first = 0;
    for (int c = 1; c <= 200 && first == 0; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) check("post rst state", st, 1);
      if (done) first = c;
    end
    check("post rst done delay", first, HOLD + GATE + 2);
    check_result("post rst", 25, 25, 25, 25, 2'b11, 1'b0);

    // Lose lock after a result, then disable while waiting for lock.
    locked = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("unlock state", st, 1);
    check("unlock loss", loss, 1);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("dis state", st, 0);
    check("dis done", done, 0);
    check("dis valid", valid, 1);
    check("dis pass", pass, 2'b11);
    check("dis cnt", cnt, {16'd25, 16'd25});
    check("dis loss", loss, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
